// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
// Holds the transmit FSM state encoding and the parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Wide enough to index up to 8 data bits or 2 stop bits.
    localparam int BIT_CNT_W = 3;

    // XOR seed for the parity accumulator: odd parity starts from 1.
    function automatic logic parity_init(input int odd);
        return (odd != 0) ? PAR_ODD : PAR_EVEN;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side port bundle of the UART transmitter plus its FSM debug state.
// ld_tx_data is a one-cycle push strobe with no ready: tx_full is the back-pressure
// indication, and a strobe while full with no same-cycle pop is dropped and flagged in tx_over_run.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic              ld_tx_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_enable;
    logic              clr_over_run;
    logic              tx_out;
    logic              tx_empty;
    logic              tx_full;
    logic              tx_busy;
    logic              tx_over_run;
    uart_tx_state_t    tx_state;

    modport master (
        output ld_tx_data, tx_data, tx_enable, clr_over_run,
        input  tx_out, tx_empty, tx_full, tx_busy, tx_over_run, tx_state
    );

    modport slave (
        input  ld_tx_data, tx_data, tx_enable, clr_over_run,
        output tx_out, tx_empty, tx_full, tx_busy, tx_over_run, tx_state
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head read; the caller qualifies push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed from an on-chip FIFO: configurable data width,
// optional even/odd parity, one or two stop bits, internal baud divider.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           txclk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);

    localparam int                   BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]    BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA   = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP   = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                 PAR_SEED    = parity_init(PARITY_ODD);

    uart_tx_state_t       state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic [DATA_W-1:0]    shift_q;
    logic                 parity_q;
    logic                 tx_out_q;
    logic                 busy_q;
    logic                 over_run_q;
    logic                 over_run_d;

    logic [DATA_W-1:0]    fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_done;
    logic                 frame_end;
    logic                 pop;
    logic                 push;
    logic                 over_run_set;

    assign bit_done  = (baud_q == '0);
    assign frame_end = (state_q == STOP) && bit_done && (bit_q == LAST_STOP);
    // A frame may start from IDLE or chain straight out of the final stop-bit cycle.
    assign pop          = bus.tx_enable && !fifo_empty && ((state_q == IDLE) || frame_end);
    assign push         = bus.ld_tx_data && (!fifo_full || pop);
    assign over_run_set = bus.ld_tx_data && fifo_full && !pop;

    uart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (txclk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.tx_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            if (!bit_done) baud_q <= baud_q - 1'b1;
            case (state_q)
                IDLE: ;
                START: begin
                    if (bit_done) begin
                        state_q  <= DATA;
                        baud_q   <= BAUD_RELOAD;
                        bit_q    <= '0;
                        tx_out_q <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_q == LAST_DATA) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q  <= PARITY;
                                tx_out_q <= parity_q;
                            end else begin
                                state_q  <= STOP;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            shift_q  <= shift_q >> 1;
                            tx_out_q <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state_q  <= STOP;
                        baud_q   <= BAUD_RELOAD;
                        bit_q    <= '0;
                        tx_out_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_q == LAST_STOP) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            tx_out_q <= 1'b1;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            baud_q <= BAUD_RELOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Loading a frame overrides whatever the case above chose.
            if (pop) begin
                state_q  <= START;
                baud_q   <= BAUD_RELOAD;
                bit_q    <= '0;
                shift_q  <= fifo_rdata;
                parity_q <= (^fifo_rdata) ^ PAR_SEED;
                tx_out_q <= 1'b0;
                busy_q   <= 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        over_run_d = over_run_q;
        if (bus.clr_over_run) over_run_d = 1'b0;
        if (over_run_set)     over_run_d = 1'b1;
    end

    always_ff @(posedge txclk) begin
        if (reset) over_run_q <= 1'b0;
        else       over_run_q <= over_run_d;
    end

    assign bus.tx_out      = tx_out_q;
    assign bus.tx_empty    = fifo_empty;
    assign bus.tx_full     = fifo_full;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_over_run = over_run_q;
    assign bus.tx_state    = state_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an on-chip transmit FIFO, successor to the fixed 8N1 transmitter. Supports configurable data width, optional parity, one or two stop bits, an internal baud divider and FIFO buffering. Sits between a host write port and the serial line; one clock domain, `txclk`.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..8.
- `CLKS_PER_BIT`, 16: `txclk` cycles per serial bit, legal ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored if `PARITY_EN`=0.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two, ≥2.
- `txclk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_tx_data` in 1: push `tx_data` into the FIFO this cycle.
- `tx_data` in DATA_W: write data.
- `tx_enable` in 1: permits new frames to start.
- `clr_over_run` in 1: clears sticky `tx_over_run`.
- `tx_out` out 1: serial line, idle high.
- `tx_empty` out 1: FIFO holds no entries.
- `tx_full` out 1: FIFO holds FIFO_DEPTH entries.
- `tx_busy` out 1: a frame is on the line, start through last stop bit.
- `tx_over_run` out 1: sticky flag, a push was dropped.

## Operation
- Reset: `tx_out`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0, `tx_over_run`=0. FIFO pointers and count cleared, FSM to IDLE, baud counter 0. Reset mid-frame aborts the frame; line high next cycle.
- Push: `ld_tx_data` && (!`tx_full` || pop this cycle) → entry written. `ld_tx_data` && `tx_full` && no pop → data dropped, `tx_over_run` set.
- `tx_over_run` cleared by `clr_over_run`; a same-cycle set wins over clear.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when `tx_enable` && !`tx_empty`; the head entry is popped into the shift register in that cycle.
  - START→DATA, DATA→(PARITY if `PARITY_EN` else STOP) after DATA_W bits, PARITY→STOP, STOP→IDLE after STOP_BITS bits.
- Each state bit is held for exactly CLKS_PER_BIT cycles. The baud counter reloads to CLKS_PER_BIT-1 at each bit start and advances the bit on 0.
- Data is sent LSB first. Parity = XOR of the data bits, inverted if `PARITY_ODD`.
- `tx_enable` gates only frame starts. Deasserting it mid-frame lets the frame complete unchanged; no new start follows.
- Back-to-back: on the last cycle of the final stop bit, if `tx_enable` && !`tx_empty`, pop and go directly to START (no idle cycle).

## Timing
- Push visible: `tx_empty` deasserts the cycle after the push edge.
- Start latency: with the FSM in IDLE, pop in cycle N, `tx_out`=0 and `tx_busy`=1 from cycle N+1.
- Frame length: CLKS_PER_BIT × (1 + DATA_W + PARITY_EN + STOP_BITS) cycles.
- Push into an empty FIFO in the same cycle as an IDLE check: no pop that cycle; pop occurs the next cycle.
- Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.

## Structure
- Package `uart_pkg` holds the FSM state enum `uart_tx_state_t` and the parity-mode constants.
- Sub-module `uart_fifo` is a synchronous FIFO with DATA_W and DEPTH parameters and push/pop/full/empty ports. The top-level holds the FSM, baud counter, shift register, parity logic and overrun flag.

## Test plan
- Default params, push 0xA5, `tx_enable`=1 → `tx_out` runs 0,1,0,1,0,0,1,0,1,1, each 16 cycles; `tx_busy` high for 160 cycles.
- `PARITY_EN`=1, `PARITY_ODD`=0, push 0x07 → parity bit 1. With `PARITY_ODD`=1 → parity bit 0. Frame length 176 cycles.
- `tx_enable`=0, 5 pushes 0x01..0x05 at depth 4 → `tx_full` after the 4th, `tx_over_run`=1 after the 5th. Then enable → exactly 0x01..0x04 sent back-to-back with no idle gap.
- Drop `tx_enable` during the DATA bits of frame 1 with 2 entries queued → frame 1 completes, line stays high, `tx_empty`=0.
- Assert `reset` mid-DATA → next cycle `tx_out`=1, `tx_empty`=1, `tx_busy`=0, `tx_over_run`=0.
- `STOP_BITS`=2, `DATA_W`=5, `CLKS_PER_BIT`=4, push 0x1F → 0, then 1×5, then 1×2; total 32 cycles.
